// File: rtl/regdump_if.sv
// Bus bundle between the register-dump sequencer and its environment:
// vblank/start, the external word mux and the text-buffer write port.
interface regdump_if #(
    parameter int ADDR_W = 11
);
    logic              vblank;
    logic [4:0]        word_sel;
    logic [31:0]       word_data;
    logic              wr_req;
    logic              wr_gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              clr_overrun;

    modport master (
        input  vblank, word_data, wr_gnt, clr_overrun,
        output word_sel, wr_req, wr_addr, wr_data, busy, frame_done, overrun
    );

    modport slave (
        output vblank, word_data, wr_gnt, clr_overrun,
        input  word_sel, wr_req, wr_addr, wr_data, busy, frame_done, overrun
    );
endinterface

// File: rtl/regdump_text_sequencer.sv
// Once per vblank rising edge, writes NUM_WORDS debug words into the text buffer as 8-digit hex.
// Optional REGDUMP_ZERO_SUPPRESS_EN: leading zeros of each word are written as spaces.
module regdump_text_sequencer #(
    parameter int NUM_WORDS  = 18,
    parameter int ADDR_W     = 11,
    parameter int ROW_BASE   = 0,
    parameter int ROW_STRIDE = 16,
    parameter int COL_OFFSET = 3
) (
    input  logic      clk,
    input  logic      rst,
    regdump_if.master bus
);

    // state | meaning
    // IDLE  | waiting for a vblank rising edge
    // LOAD  | word k selected on the mux, latched into sh
    // WRITE | emitting the 8 digits of word k, one per grant
    // DONE  | one-cycle frame_done pulse
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        k_q, k_d;
    logic [2:0]        nib_q, nib_d;
    logic [31:0]       sh_q, sh_d;
    logic              vblank_q, vblank_d;
    logic              overrun_q, overrun_d;
    logic              start;
    logic [3:0]        digit;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        chr;
`ifdef REGDUMP_ZERO_SUPPRESS_EN
    logic              nz_seen_q, nz_seen_d;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + {4'h0, d};
        else           return 8'h37 + {4'h0, d};
    endfunction

    assign start = bus.vblank & ~vblank_q;
    assign digit = sh_q[31:28];
    // Address wraps naturally at ADDR_W bits.
    assign addr  = ADDR_W'(ROW_BASE + int'(k_q) * ROW_STRIDE + COL_OFFSET + int'(nib_q));

`ifdef REGDUMP_ZERO_SUPPRESS_EN
    assign chr = (!nz_seen_q && digit == 4'h0 && nib_q != 3'd7) ? 8'h20 : hex_char(digit);
`else
    assign chr = hex_char(digit);
`endif

    assign bus.word_sel = k_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.overrun  = overrun_q;

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        nib_d          = nib_q;
        sh_d           = sh_q;
        vblank_d       = bus.vblank;
        overrun_d      = overrun_q;
`ifdef REGDUMP_ZERO_SUPPRESS_EN
        nz_seen_d      = nz_seen_q;
`endif
        bus.wr_req     = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;

        if (start && state_q != IDLE) overrun_d = 1'b1;
        else if (bus.clr_overrun)     overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            LOAD: begin
                sh_d      = bus.word_data;
                nib_d     = '0;
`ifdef REGDUMP_ZERO_SUPPRESS_EN
                nz_seen_d = 1'b0;
`endif
                state_d   = WRITE;
            end
            WRITE: begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = addr;
                bus.wr_data = chr;
                if (bus.wr_gnt) begin
                    sh_d  = {sh_q[27:0], 4'h0};
                    nib_d = nib_q + 3'd1;
`ifdef REGDUMP_ZERO_SUPPRESS_EN
                    nz_seen_d = nz_seen_q | (digit != 4'h0);
`endif
                    if (nib_q == 3'd7) begin
                        if (k_q == 5'(NUM_WORDS - 1)) begin
                            state_d = DONE;
                        end else begin
                            k_d     = k_q + 5'd1;
                            state_d = LOAD;
                        end
                    end
                end
            end
            DONE: begin
                bus.frame_done = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            nib_q     <= '0;
            sh_q      <= '0;
            vblank_q  <= 1'b0;
            overrun_q <= 1'b0;
`ifdef REGDUMP_ZERO_SUPPRESS_EN
            nz_seen_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            nib_q     <= nib_d;
            sh_q      <= sh_d;
            vblank_q  <= vblank_d;
            overrun_q <= overrun_d;
`ifdef REGDUMP_ZERO_SUPPRESS_EN
            nz_seen_q <= nz_seen_d;
`endif
        end
    end

endmodule

// File: tb/tb_regdump_text_sequencer.sv
// Bench for regdump_text_sequencer: expected text is derived from the word values by a
// per-digit model and scoreboarded against every accepted write.
`timescale 1ns/1ps
module tb_regdump_text_sequencer;
    localparam int NUM_WORDS  = 18;
    localparam int ADDR_W     = 11;
    localparam int ROW_BASE   = 0;
    localparam int ROW_STRIDE = 16;
    localparam int COL_OFFSET = 3;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    regdump_if #(.ADDR_W(ADDR_W)) bus();

    regdump_text_sequencer #(
        .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .ROW_BASE(ROW_BASE),
        .ROW_STRIDE(ROW_STRIDE), .COL_OFFSET(COL_OFFSET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [NUM_WORDS];
    assign bus.word_data = (int'(bus.word_sel) < NUM_WORDS) ? regs[bus.word_sel] : 32'h0;

    int checks = 0;
    int passed = 0;
    bit chk_en = 0;
    bit gnt_rand = 0;
    bit gnt_fix = 1;
    int done_cnt = 0;
    int nacc = 0;
    bit stall_pend = 0;
    logic [ADDR_W+7:0] held;
    logic [ADDR_W+7:0] exp_q [$];
    logic [7:0] captured [DEPTH];
    int wcnt [DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Digit n (0 = most significant) of v as it should appear on screen.
    function automatic logic [7:0] model_char(input logic [31:0] v, input int n);
        logic [31:0] upper;
        logic [3:0]  d;
        upper = v >> (4 * (7 - n));
        d     = upper[3:0];
`ifdef REGDUMP_ZERO_SUPPRESS_EN
        if (n < 7 && upper == 32'h0) return 8'h20;
`endif
        if (d < 4'd10) return 8'h30 + 8'(d);
        else           return 8'h41 + 8'(d) - 8'd10;
    endfunction

    function automatic int model_addr(input int w, input int n);
        return (ROW_BASE + w * ROW_STRIDE + COL_OFFSET + n) % DEPTH;
    endfunction

    task automatic build_expected();
        for (int w = 0; w < NUM_WORDS; w++)
            for (int n = 0; n < 8; n++)
                exp_q.push_back({ADDR_W'(model_addr(w, n)), model_char(regs[w], n)});
    endtask

    task automatic clear_stats();
        for (int i = 0; i < DEPTH; i++) begin
            captured[i] = 8'h00;
            wcnt[i]     = 0;
        end
        nacc = 0;
    endtask

    function automatic logic [63:0] row_text(input int a);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], captured[a + i]};
        return r;
    endfunction

    // Raises vblank so that the next posedge is the sampling edge, and returns right after it.
    task automatic start_sweep();
        build_expected();
        @(posedge clk); #1 bus.vblank = 1'b0;
        @(posedge clk); #1 bus.vblank = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_done(input string name, input int bound);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (bus.frame_done) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic post_sweep(input string tag);
        int bad;
        repeat (3) @(negedge clk);
        bad = 0;
        for (int w = 0; w < NUM_WORDS; w++)
            for (int n = 0; n < 8; n++)
                if (wcnt[model_addr(w, n)] != 1) bad++;
        check({tag, "_accepted_writes"}, nacc, 144);
        check({tag, "_addr_once"}, bad, 0);
        check({tag, "_scoreboard_drained"}, exp_q.size(), 0);
        check({tag, "_idle_after"}, bus.busy, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (gnt_rand) bus.wr_gnt = ($urandom_range(0, 99) < 30);
        else          bus.wr_gnt = gnt_fix;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (stall_pend)
                check("stall_hold", {bus.wr_req, bus.wr_addr, bus.wr_data}, {1'b1, held});
            stall_pend = 0;
            check("req_only_when_busy", bus.wr_req & ~bus.busy, 0);
            if (bus.frame_done) done_cnt++;
            if (bus.wr_req && bus.wr_gnt) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("write_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
                captured[bus.wr_addr] = bus.wr_data;
                wcnt[bus.wr_addr]++;
                nacc++;
            end else if (bus.wr_req) begin
                stall_pend = 1;
                held       = {bus.wr_addr, bus.wr_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  ok;
        int  d0;

        rst             = 1'b1;
        bus.vblank      = 1'b0;
        bus.clr_overrun = 1'b0;
        regs[0]  = 32'h0040_00A8;
        regs[1]  = 32'h1234_5678;
        regs[2]  = 32'h0000_0100;
        regs[3]  = 32'h0000_0000;
        for (int w = 4; w < 17; w++) regs[w] = 32'h9ABC_DEF0 + 32'(w);
        regs[17] = 32'hDEAD_BEEF;
        clear_stats();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_req", bus.wr_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_word_sel", bus.word_sel, 0);
        check("rst_wr_addr_data", {bus.wr_addr, bus.wr_data}, 0);
        chk_en = 1;

        // Grant tied high: exact latency and sweep length.
        start_sweep();
        n  = 0;
        ok = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("load_cycle_no_req", bus.wr_req, 0);
                check("busy_in_load", bus.busy, 1);
            end
            if (n == 2) check("first_req_latency", bus.wr_req, 1);
            if (bus.frame_done) begin
                ok = 1;
                break;
            end
        end
        check("sweep1_done_seen", ok, 1);
        check("sweep1_len", n, 163);
        post_sweep("sweep1");
        check("pc_text", row_text(3), "004000A8");
        check("r16_text", row_text(275), 64'h4445_4144_4245_4546);
`ifdef REGDUMP_ZERO_SUPPRESS_EN
        check("r1_text", row_text(35), "     100");
        check("r2_text", row_text(51), "       0");
`else
        check("r1_text", row_text(35), "00000100");
        check("r2_text", row_text(51), "00000000");
`endif

        // Random 30% grant, with a vblank rise while busy.
        clear_stats();
        gnt_rand = 1;
        start_sweep();
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1 bus.vblank = 1'b0;
        @(posedge clk); #1 bus.vblank = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("overrun_set", bus.overrun, 1);
        check("busy_after_overrun", bus.busy, 1);
        wait_done("sweep2_done_seen", 5000);
        post_sweep("sweep2");
        check("sweep2_one_frame", done_cnt - d0, 1);
        check("overrun_sticky", bus.overrun, 1);

        @(posedge clk); #1 bus.clr_overrun = 1'b1;
        @(posedge clk); #1 bus.clr_overrun = 1'b0;
        @(negedge clk);
        check("overrun_cleared", bus.overrun, 0);

        // clr_overrun on the same edge that samples a new overrun: set wins.
        clear_stats();
        start_sweep();
        repeat (20) @(posedge clk);
        #1 bus.vblank = 1'b0;
        @(posedge clk); #1 begin bus.vblank = 1'b1; bus.clr_overrun = 1'b1; end
        @(posedge clk); #1 bus.clr_overrun = 1'b0;
        @(negedge clk);
        check("overrun_set_beats_clr", bus.overrun, 1);
        wait_done("sweep3_done_seen", 5000);
        post_sweep("sweep3");

        // Reset during word 5.
        clear_stats();
        gnt_rand = 0;
        gnt_fix  = 1;
        start_sweep();
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.word_sel == 5'd5 && bus.wr_req) begin
                ok = 1;
                break;
            end
        end
        check("reached_word5", ok, 1);
        d0 = done_cnt;
        #2 begin rst = 1'b1; bus.vblank = 1'b0; end
        #1;
        check("midrst_wr_req", bus.wr_req, 0);
        check("midrst_busy", bus.busy, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_frame_done", done_cnt - d0, 0);
        check("midrst_stays_idle", bus.busy, 0);

        clear_stats();
        start_sweep();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wr_req && bus.wr_gnt) begin
                ok = 1;
                break;
            end
        end
        check("restart_write_seen", ok, 1);
        check("restart_addr", bus.wr_addr, 3);
        check("restart_word_sel", bus.word_sel, 0);
        wait_done("sweep4_done_seen", 400);
        post_sweep("sweep4");
        check("sweep4_pc_text", row_text(3), "004000A8");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
